mem_port_arbiter: RTL

//  Shares the single unified instruction/data memory between the IF-stage fetch port and the MEM-stage load/store port.
//  - Grants one requester per cycle.
//  - Drives the memory command and routes the 1-cycle-latency read data back to the owning requester.
//  - A denied grant is the stall source for that pipeline stage.

---
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified instruction/data memory between the
// IF-stage fetch port and the MEM-stage load/store port. Grants are
// combinational (a denied grant stalls that stage); read data returns one
// cycle after the grant and is routed by a registered owner tag.
// Optional feature macro: MEM_ARB_FAIR_EN (bounded data priority: after
// FAIR_LIMIT consecutive data grants with fetch waiting, fetch wins a cycle).
module mem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int FAIR_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DATA = 2'd2
    } owner_e;

    owner_e owner_q;
    owner_e owner_d;
    logic   if_gnt_s;
    logic   d_gnt_s;
    logic   force_if_s;

    // Byte-offset bits are ignored by a word-addressed memory.
    logic unused_s;
    assign unused_s = ^{if_addr[1:0], d_addr[1:0], 3'(FAIR_LIMIT)};

`ifdef MEM_ARB_FAIR_EN
    localparam logic [2:0] LIMIT = 3'(FAIR_LIMIT);

    logic [2:0] streak_q;
    logic [2:0] streak_d;

    // Fetch is forced once data has won LIMIT times in a row while fetch waited.
    always_comb begin
        force_if_s = if_req & d_req & (streak_q == LIMIT);
    end

    // Streak counts data grants that starved a waiting fetch; saturates at LIMIT.
    always_comb begin
        streak_d = streak_q;
        if (!if_req || if_gnt_s) begin
            streak_d = 3'd0;
        end else if (d_gnt_s && (streak_q < LIMIT)) begin
            streak_d = streak_q + 3'd1;
        end else begin
            streak_d = streak_q;
        end
    end

    // Streak register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= 3'd0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    assign force_if_s = 1'b0;
`endif

    // Arbitration: data (older instruction) wins unless fetch is being forced;
    // grants are held low while reset is asserted.
    always_comb begin
        if_gnt_s = 1'b0;
        d_gnt_s  = 1'b0;
        if (!rst_n) begin
            if_gnt_s = 1'b0;
            d_gnt_s  = 1'b0;
        end else if (d_req && !force_if_s) begin
            d_gnt_s = 1'b1;
        end else if (if_req) begin
            if_gnt_s = 1'b1;
        end else begin
            if_gnt_s = 1'b0;
            d_gnt_s  = 1'b0;
        end
    end

    assign if_gnt = if_gnt_s;
    assign d_gnt  = d_gnt_s;

    // Memory command driven by whichever port holds the grant.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = {(ADDR_W-2){1'b0}};
        mem_wdata = 32'h0000_0000;
        case ({d_gnt_s, if_gnt_s})
            2'b10: begin
                mem_en    = 1'b1;
                mem_we    = d_we;
                mem_be    = d_we ? d_be : 4'hF;
                mem_addr  = d_addr[ADDR_W-1:2];
                mem_wdata = d_we ? d_wdata : 32'h0000_0000;
            end
            2'b01: begin
                mem_en   = 1'b1;
                mem_we   = 1'b0;
                mem_be   = 4'hF;
                mem_addr = if_addr[ADDR_W-1:2];
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    // Next owner: tag the read granted this cycle; stores and idle cycles own nothing.
    always_comb begin
        owner_d = OWN_NONE;
        if (if_gnt_s) begin
            owner_d = OWN_IF;
        end else if (d_gnt_s && !d_we) begin
            owner_d = OWN_DATA;
        end else begin
            owner_d = OWN_NONE;
        end
    end

    // Owner register; reset drops any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Route returning read data to its owner; the other port sees zero.
    always_comb begin
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if_rdata  = 32'h0000_0000;
        d_rdata   = 32'h0000_0000;
        case (owner_q)
            OWN_IF: begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end
            OWN_DATA: begin
                d_rvalid = 1'b1;
                d_rdata  = mem_rdata;
            end
            default: begin
                if_rvalid = 1'b0;
                d_rvalid  = 1'b0;
            end
        endcase
    end

endmodule
